// File: rtl/mult_unit.sv
// Sequential radix-2 shift-add multiplier (MUL / UMULH / SMULH) feeding a register-file write port.
// Optional macro MULT_UNIT_SIGNED_EN enables signed handling of Op=10; otherwise Op=10 behaves as UMULH.
module mult_unit #(
   parameter int WIDTH = 64
) (
   input  logic             Clk,
   input  logic             ResetL,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic [4:0]       RWIn,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] BusW,
   output logic [4:0]       RW,
   output logic             RegWr
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} stateT;

   stateT              stateReg, stateNext;
   logic [CW-1:0]      countReg;
   logic [2*WIDTH-1:0] productReg, mcandReg, productNext, productFinal;
   logic [WIDTH-1:0]   mplierReg, resultSel, opA, opB;
   logic [1:0]         opReg;
   logic               accept, lastStep;
   logic               busyNext, doneNext, regWrNext;

   assign accept   = Start && (stateReg == IDLE || stateReg == DONE);
   assign lastStep = (stateReg == BUSY) && (countReg == LAST);

`ifdef MULT_UNIT_SIGNED_EN
   logic negReg, negIn;
   // Signed high half: multiply magnitudes, fix the sign of the full product at the end.
   assign negIn = (Op == 2'b10) && (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
   assign opA   = (Op == 2'b10 && BusA[WIDTH-1]) ? -BusA : BusA;
   assign opB   = (Op == 2'b10 && BusB[WIDTH-1]) ? -BusB : BusB;
   assign productFinal = negReg ? -productNext : productNext;

   always_ff @(posedge Clk or negedge ResetL) begin
      if (!ResetL) begin
         negReg <= 1'b0;
      end else if (accept) begin
         negReg <= negIn;
      end
   end
`else
   assign opA          = BusA;
   assign opB          = BusB;
   assign productFinal = productNext;
`endif

   assign productNext = mplierReg[0] ? (productReg + mcandReg) : productReg;
   assign resultSel   = (opReg == 2'b01 || opReg == 2'b10) ? productFinal[2*WIDTH-1:WIDTH]
                                                           : productFinal[WIDTH-1:0];

   always_ff @(posedge Clk or negedge ResetL) begin
      if (!ResetL) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      busyNext  = 1'b0;
      doneNext  = 1'b0;
      regWrNext = 1'b0;
      case (stateReg)
         IDLE:    if (Start) stateNext = BUSY;
         BUSY:    if (countReg == LAST) stateNext = DONE;
         DONE:    stateNext = Start ? BUSY : IDLE;
         default: stateNext = IDLE;
      endcase
      busyNext  = (stateNext == BUSY);
      doneNext  = lastStep;
      regWrNext = lastStep && (RW != 5'd31);
   end

   always_ff @(posedge Clk or negedge ResetL) begin
      if (!ResetL) begin
         countReg   <= '0;
         productReg <= '0;
         mcandReg   <= '0;
         mplierReg  <= '0;
         opReg      <= 2'b00;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         RegWr      <= 1'b0;
         BusW       <= '0;
         RW         <= 5'd0;
      end else begin
         Busy  <= busyNext;
         Done  <= doneNext;
         RegWr <= regWrNext;
         if (accept) begin
            countReg   <= '0;
            productReg <= '0;
            mcandReg   <= {{WIDTH{1'b0}}, opA};
            mplierReg  <= opB;
            opReg      <= Op;
            RW         <= RWIn;
         end else if (stateReg == BUSY) begin
            countReg   <= countReg + 1'b1;
            productReg <= productNext;
            mcandReg   <= mcandReg << 1;
            mplierReg  <= mplierReg >> 1;
            // BusW only moves on completion so it stays settled through DONE and IDLE.
            if (lastStep) BusW <= resultSel;
         end
      end
   end
endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: cycle model compared every cycle plus literal expectations per operation.
module tb_mult_unit;
   localparam int W = 64;

   logic           Clk = 1'b0, ResetL = 1'b1, Start = 1'b0;
   logic [1:0]     Op = 2'b00;
   logic [W-1:0]   BusA = '0, BusB = '0;
   logic [4:0]     RWIn = 5'd0;
   logic           Busy, Done, RegWr;
   logic [W-1:0]   BusW;
   logic [4:0]     RW;
   int             checks = 0, failures = 0;

   always #5 Clk = ~Clk;

   mult_unit #(.WIDTH(W)) dut (
      .Clk(Clk), .ResetL(ResetL), .Start(Start), .Op(Op), .BusA(BusA), .BusB(BusB),
      .RWIn(RWIn), .Busy(Busy), .Done(Done), .BusW(BusW), .RW(RW), .RegWr(RegWr)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Result from plain wide arithmetic on the operands.
   function automatic logic [W-1:0] modelResult(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`ifdef MULT_UNIT_SIGNED_EN
      if (op == 2'b10) p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
`endif
      return (op == 2'b01 || op == 2'b10) ? p[2*W-1:W] : p[W-1:0];
   endfunction

   // Model: a request occupies the unit for W cycles, then a one-cycle completion.
   int           mRemain = 0;
   logic [W-1:0] mPend = '0, mBusW = '0;
   logic [4:0]   mRW = 5'd0;
   logic         mDone = 1'b0, mRegWr = 1'b0;

   always @(posedge Clk or negedge ResetL) begin
      if (!ResetL) begin
         mRemain = 0; mPend = '0; mBusW = '0; mRW = 5'd0; mDone = 1'b0; mRegWr = 1'b0;
      end else begin
         mDone = 1'b0;
         mRegWr = 1'b0;
         if (mRemain > 0) begin
            mRemain--;
            if (mRemain == 0) begin
               mDone = 1'b1;
               mRegWr = (mRW != 5'd31);
               mBusW = mPend;
            end
         end else if (Start) begin
            mRemain = W;
            mRW = RWIn;
            mPend = modelResult(Op, BusA, BusB);
         end
      end
   end

   always @(negedge Clk) begin
      chk("cyc_busy",  W'(Busy),  W'(mRemain > 0));
      chk("cyc_done",  W'(Done),  W'(mDone));
      chk("cyc_regwr", W'(RegWr), W'(mRegWr));
      chk("cyc_busw",  BusW,      mBusW);
      chk("cyc_rw",    W'(RW),    W'(mRW));
   end

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rw);
      @(posedge Clk); #1;
      Start = 1'b1; Op = op; BusA = a; BusB = b; RWIn = rw;
      @(posedge Clk); #1;
      Start = 1'b0;
   endtask

   task automatic waitDone(output int busyCycles, output bit seen);
      busyCycles = 0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge Clk);
         if (Done) seen = 1'b1;
         else if (Busy) busyCycles++;
      end
   endtask

   task automatic checkOp(input string name, input logic [W-1:0] expW, input logic [4:0] expRw,
                          input bit expWr, input int busyCycles, input int expBusy, input bit seen);
      chk({name, "_seen"}, W'(seen), W'(1));
      chk({name, "_busw"}, BusW, expW);
      chk({name, "_rw"}, W'(RW), W'(expRw));
      chk({name, "_regwr"}, W'(RegWr), W'(expWr));
      if (expBusy >= 0) chk({name, "_busycnt"}, W'(busyCycles), W'(expBusy));
      $display("op %s busw=%h rw=%0d regwr=%0b busy=%0d", name, BusW, RW, RegWr, busyCycles);
   endtask

   initial begin
      int  bc, doneCnt;
      bit  seen;
      logic [W-1:0] smulhExp;

      #2 ResetL = 1'b0;
      @(negedge Clk);
      chk("rst_busy", W'(Busy), '0);
      chk("rst_done", W'(Done), '0);
      chk("rst_busw", BusW, '0);
      chk("rst_rw", W'(RW), '0);
      chk("rst_regwr", W'(RegWr), '0);
      @(posedge Clk); #1 ResetL = 1'b1;

      issue(2'b00, 64'd3, 64'd5, 5'd2);
      waitDone(bc, seen);
      checkOp("mul_3x5", 64'd15, 5'd2, 1'b1, bc, 64, seen);

      issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7);
      waitDone(bc, seen);
      checkOp("umulh_max", 64'hFFFF_FFFF_FFFF_FFFE, 5'd7, 1'b1, bc, 64, seen);

`ifdef MULT_UNIT_SIGNED_EN
      smulhExp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
      smulhExp = 64'h1;
`endif
      issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd8);
      waitDone(bc, seen);
      checkOp("smulh_m1x2", smulhExp, 5'd8, 1'b1, bc, 64, seen);

      issue(2'b11, 64'd3, 64'd5, 5'd1);
      waitDone(bc, seen);
      checkOp("reserved_3x5", 64'd15, 5'd1, 1'b1, bc, 64, seen);

      issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 64'h8000_0000_0000_0005, 5'd9);
      waitDone(bc, seen);
      checkOp("smulh_mix", modelResult(2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 64'h8000_0000_0000_0005),
              5'd9, 1'b1, bc, 64, seen);

      issue(2'b00, 64'd0, 64'd0, 5'd5);
      waitDone(bc, seen);
      checkOp("mul_zero", 64'd0, 5'd5, 1'b1, bc, 64, seen);

      // XZR destination with a Start pulse in the middle of the operation.
      issue(2'b00, 64'd7, 64'd9, 5'd31);
      repeat (10) @(posedge Clk);
      #1 Start = 1'b1; BusA = 64'd100; BusB = 64'd100; RWIn = 5'd4;
      @(posedge Clk); #1 Start = 1'b0;
      waitDone(bc, seen);
      checkOp("mul_xzr", 64'd63, 5'd31, 1'b0, bc, -1, seen);
      @(negedge Clk);
      chk("xzr_no_restart", W'(Busy), '0);

      // Reset during cycle 30 of BUSY.
      issue(2'b00, 64'd3, 64'd5, 5'd9);
      repeat (29) @(posedge Clk);
      #1 ResetL = 1'b0;
      #1;
      chk("abort_busy", W'(Busy), '0);
      chk("abort_busw", BusW, '0);
      chk("abort_rw", W'(RW), '0);
      doneCnt = 0;
      repeat (70) begin
         @(negedge Clk);
         if (Done || RegWr) doneCnt++;
      end
      chk("abort_no_done", W'(doneCnt), '0);
      @(posedge Clk); #1;
      ResetL = 1'b1; Start = 1'b1; Op = 2'b00; BusA = 64'd11; BusB = 64'd13; RWIn = 5'd3;
      @(posedge Clk); #1 Start = 1'b0;
      @(negedge Clk);
      chk("post_rst_busy", W'(Busy), W'(1));
      waitDone(bc, seen);
      checkOp("post_rst_mul", 64'd143, 5'd3, 1'b1, bc, 63, seen);

      // Back-to-back: Start raised during the DONE cycle.
      Start = 1'b1; Op = 2'b00; BusA = 64'd6; BusB = 64'd7; RWIn = 5'd12;
      @(posedge Clk); #1 Start = 1'b0;
      @(negedge Clk);
      chk("b2b_busy", W'(Busy), W'(1));
      chk("b2b_done", W'(Done), '0);
      chk("b2b_busw_hold", BusW, 64'd143);
      waitDone(bc, seen);
      checkOp("b2b_mul", 64'd42, 5'd12, 1'b1, bc, 63, seen);

      repeat (3) @(negedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
